// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: 33-bit packet field map, packet type codes and
// the receive-side FSM state encoding.
package noc_pkg;

  localparam int PKT_W    = 33;
  localparam int LOC_W    = 5;
  localparam int TYPE_W   = 2;
  localparam int PAY_W    = 21;

  localparam int DEST_MSB = 32;
  localparam int DEST_LSB = 28;
  localparam int SRC_MSB  = 27;
  localparam int SRC_LSB  = 23;
  localparam int TYPE_MSB = 22;
  localparam int TYPE_LSB = 21;
  localparam int PAY_MSB  = 20;
  localparam int PAY_LSB  = 0;

  typedef logic [LOC_W-1:0] loc_t;

  typedef enum logic [TYPE_W-1:0] {
    PKT_WGT   = 2'b00,
    PKT_IFMAP = 2'b01,
    PKT_SPIKE = 2'b10,
    PKT_CTRL  = 2'b11
  } pkt_type_e;

  typedef struct packed {
    loc_t             dest;
    loc_t             src;
    pkt_type_e        ptype;
    logic [PAY_W-1:0] payload;
  } packet_t;

  // What the PE needs once routing is done: destination is stripped.
  typedef struct packed {
    loc_t             src;
    pkt_type_e        ptype;
    logic [PAY_W-1:0] payload;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_PUSH  = 2'b10,
    ST_ACK   = 2'b11
  } rx_state_e;

endpackage

// File: rtl/noc_rx_fifo.sv
// Synchronous receive FIFO with registered full flag and occupancy level.
// Head data reads as zero while empty.
module noc_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_next;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  // A push against a full FIFO is refused even if a pop happens the same cycle.
  assign do_push = push && !full_q;
  assign do_pop  = pop && (count != '0);

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_q <= (count_next == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign valid = (count != '0);
  assign rdata = valid ? mem[rd_ptr] : '0;
  assign full  = full_q;
  assign level = count;

endmodule

// File: rtl/noc_pe_rx_if.sv
// Receive end of a router pe_mem port: 2-phase bundled-data in, filtered and
// buffered valid/ready stream out to the PE/MEM core.
module noc_pe_rx_if
  import noc_pkg::*;
#(
  parameter int         WIDTH_PACKAGE = 33,
  parameter logic [4:0] LOCAL_LOC     = 5'b00000,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_req,
  input  logic [WIDTH_PACKAGE-1:0]      in_data,
  output logic                          in_ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4:0]                    out_src,
  output logic [1:0]                    out_type,
  output logic [20:0]                   out_payload,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  // state | meaning
  // IDLE  | waiting for req_s != in_ack; captures in_data on a new request
  // CHECK | compares held destination with LOCAL_LOC
  // PUSH  | writes held packet into FIFO; stalls (no ack) while FIFO full
  // ACK   | toggles in_ack, returning the 2-phase acknowledge

  rx_state_e                state_q;
  rx_state_e                state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     req_s;
  logic                     pending;
  logic [WIDTH_PACKAGE-1:0] hold_q;
  logic                     hold_load;
  logic                     drop_inc;
  logic                     ack_toggle;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  loc_t                     hold_dest;
  entry_t                   wr_entry;
  entry_t                   head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], in_req};
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = (req_s != in_ack);

  assign hold_dest        = hold_q[DEST_MSB:DEST_LSB];
  assign wr_entry.src     = hold_q[SRC_MSB:SRC_LSB];
  assign wr_entry.ptype   = pkt_type_e'(hold_q[TYPE_MSB:TYPE_LSB]);
  assign wr_entry.payload = hold_q[PAY_MSB:PAY_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    hold_load  = 1'b0;
    drop_inc   = 1'b0;
    fifo_push  = 1'b0;
    ack_toggle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          hold_load = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hold_dest == LOCAL_LOC) begin
          state_d = ST_PUSH;
        end else begin
          drop_inc = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_PUSH: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_toggle = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // in_data is only guaranteed stable while a request is outstanding, so it is
  // captured once in IDLE and everything downstream works from the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      in_ack   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (hold_load)                       hold_q   <= in_data;
      if (ack_toggle)                      in_ack   <= ~in_ack;
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign fifo_pop = out_valid && out_ready;

  noc_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .valid (out_valid),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign out_src     = head.src;
  assign out_type    = head.ptype;
  assign out_payload = head.payload;

endmodule

// File: tb/tb_noc_pe_rx_if.sv
// Scoreboard bench for noc_pe_rx_if: a router model drives 2-phase packets,
// a monitor checks every accepted head against the expected queue.
module tb_noc_pe_rx_if;

  localparam int         SYNC  = 2;
  localparam int         DEPTH = 4;
  localparam logic [4:0] LOC   = 5'b00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_req;
  logic [32:0] in_data;
  logic        in_ack;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_src;
  logic [1:0]  out_type;
  logic [20:0] out_payload;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];

  noc_pe_rx_if #(
    .WIDTH_PACKAGE (33),
    .LOCAL_LOC     (LOC),
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_req      (in_req),
    .in_data     (in_data),
    .in_ack      (in_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_src     (out_src),
    .out_type    (out_type),
    .out_payload (out_payload),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: handshake completes on the next rising edge, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", {out_src, out_type, out_payload});
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        if ({out_src, out_type, out_payload} !== e) begin
          errors++;
          $display("FAIL head_data actual=%h required=%h", {out_src, out_type, out_payload}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [4:0] dest, input logic [4:0] src,
                      input logic [1:0] t, input logic [20:0] p);
    in_data = {dest, src, t, p};
    if (dest == LOC) exp_q.push_back({src, t, p});
    in_req = ~in_req;
  endtask

  // Counts rising edges after the request toggle until in_ack matches in_req.
  task automatic wait_ack(input int max_cyc, output logic ok, output int cyc);
    cyc = 0;
    while ((in_ack != in_req) && (cyc < max_cyc)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ok = (in_ack == in_req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic ok;
  int   cyc;

  initial begin
    rst_n     = 1'b0;
    in_req    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step(3);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_out_fields", {out_src, out_type, out_payload}, 0);
    rst_n = 1'b1;
    step(2);

    // Single local packet. The first edge that samples the toggle is edge 1;
    // ack lands SYNC+3 cycles later, i.e. on edge SYNC+4.
    send(LOC, 5'b01010, 2'b01, 21'h1ABCD);
    wait_ack(20, ok, cyc);
    chk("single_acked", ok, 1);
    chk("single_ack_latency", cyc, SYNC + 4);
    chk("single_out_valid", out_valid, 1);
    chk("single_level", fifo_level, 1);
    out_ready = 1'b1;
    step(1);
    chk("single_drained", fifo_level, 0);

    // Misrouted packets: acked one cycle sooner (no PUSH), counted, never output.
    send(5'b00001, 5'b00011, 2'b10, 21'h00055);
    wait_ack(20, ok, cyc);
    chk("drop_acked", ok, 1);
    chk("drop_ack_latency", cyc, SYNC + 3);
    chk("drop_cnt_one", drop_cnt, 1);
    for (int i = 1; i < 256; i++) begin
      send(5'(1 + (i % 31)), 5'(i), 2'(i), 21'(i));
      wait_ack(20, ok, cyc);
      if (!ok) chk("drop_loop_ack", ok, 1);
    end
    chk("drop_cnt_sat", drop_cnt, 255);
    chk("drop_no_valid", out_valid, 0);

    // Fill FIFO with ready low; fifth packet must stall without ack.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(LOC, 5'(i + 4), 2'(i), 21'(i));
      wait_ack(20, ok, cyc);
      chk("fill_acked", ok, 1);
    end
    chk("full_level", fifo_level, DEPTH);
    send(LOC, 5'b11111, 2'b11, 21'd4);
    wait_ack(30, ok, cyc);
    chk("fifth_not_acked", ok, 0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    wait_ack(20, ok, cyc);
    chk("fifth_acked_after_pop", ok, 1);
    chk("refill_level", fifo_level, DEPTH);
    out_ready = 1'b1;
    step(8);
    chk("full_drained_level", fifo_level, 0);
    chk("full_drained_queue", exp_q.size(), 0);

    // Simultaneous push and pop at level 2.
    out_ready = 1'b0;
    send(LOC, 5'b00101, 2'b00, 21'h10000);
    wait_ack(20, ok, cyc);
    send(LOC, 5'b00110, 2'b01, 21'h10001);
    wait_ack(20, ok, cyc);
    chk("pp_level_before", fifo_level, 2);
    send(LOC, 5'b00111, 2'b10, 21'h10002);
    step(4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("pp_level_after", fifo_level, 2);
    chk("pp_head_advanced", out_payload, 21'h10001);
    wait_ack(20, ok, cyc);
    chk("pp_acked", ok, 1);
    out_ready = 1'b1;
    step(6);
    chk("pp_drained", fifo_level, 0);

    // Back-to-back requests: router toggles again as soon as it sees the ack.
    for (int i = 0; i < 8; i++) begin
      send(LOC, 5'(i * 3), 2'(i), 21'h0F000 + 21'(i * 17));
      wait_ack(20, ok, cyc);
      chk("b2b_acked", ok, 1);
    end
    chk("b2b_parity", in_ack, in_req);
    step(4);
    chk("b2b_all_delivered", exp_q.size(), 0);

    // Asynchronous reset while stalled in PUSH with a full FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(LOC, 5'b10001, 2'b11, 21'h00A00 + 21'(i));
      wait_ack(20, ok, cyc);
    end
    send(LOC, 5'b10010, 2'b11, 21'h00AFF);
    step(10);
    #2;
    rst_n  = 1'b0;
    in_req = 1'b0;
    #1;
    chk("arst_in_ack", in_ack, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    step(2);
    send(LOC, 5'b01100, 2'b10, 21'h12345);
    wait_ack(20, ok, cyc);
    chk("post_rst_acked", ok, 1);
    chk("post_rst_latency", cyc, SYNC + 4);
    chk("post_rst_level", fifo_level, 1);
    out_ready = 1'b1;
    step(3);
    chk("post_rst_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
